// File: rtl/bcd_count_pkg.sv
// Shared types and constants for the BCD run counter.
// Optional wrap-around mode: BCD_COUNT_WRAP_EN.
package bcd_count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COUNT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [31:0] pow10_m1(input int d);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < d; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/bcd_count_n_bin2bcd_seq.sv
// Iterative double-dabble: one shift-add-3 step per clock, MAX_W steps.
// bcd/valid present the result of the step taken on the current edge.
module bin2bcd_seq
  import bcd_count_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MAX_W  = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [MAX_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(MAX_W + 1);

  logic [MAX_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    adj, step;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             act_q, act_d;
  logic             last;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    step = (adj << 1) | BW'(sh_q[MAX_W-1]);
    last = act_q && (cnt_q == CW'(MAX_W - 1));

    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = '0;
      act_d = 1'b1;
    end else if (act_q) begin
      sh_d  = sh_q << 1;
      bcd_d = step;
      cnt_d = cnt_q + 1'b1;
      act_d = !last;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign bcd   = step;
  assign valid = last;

endmodule

// File: rtl/bcd_count_n.sv
// Multi-digit BCD run counter: latch limit, convert, count up/down.
// Define BCD_COUNT_WRAP_EN to reload the start value after each terminal.
module bcd_count_n
  import bcd_count_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MAX_W  = 7
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                run,
  input  logic                down,
  input  logic [MAX_W-1:0]    max_count,
  output logic [4*DIGITS-1:0] digits,
  output logic                busy,
  output logic                done
);

  localparam int          BW    = 4 * DIGITS;
  localparam logic [31:0] CLAMP = pow10_m1(DIGITS);

  state_t          state_q, state_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic [BW-1:0]   lim_q, lim_d;
  logic            down_q, down_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            conv_start;
  logic            cv_valid;
  logic [BW-1:0]   cv_bcd;
  logic [MAX_W-1:0] lim_bin;
  logic [BW-1:0]   start_v, term_v, nxt;
  logic [BW-1:0]   cand, tgt;
  logic            step_en, hit;

  function automatic logic [BW-1:0] bcd_step(
    input logic [BW-1:0] v,
    input logic          dn
  );
    logic [BW-1:0] r;
    logic          c;
    logic [3:0]    d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (!dn) begin
          c = (d == BCD_NINE);
          r[4*i +: 4] = c ? BCD_ZERO : d + 4'd1;
        end else begin
          c = (d == BCD_ZERO);
          r[4*i +: 4] = c ? BCD_NINE : d - 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    lim_bin = max_count;
    if ({{(32-MAX_W){1'b0}}, max_count} > CLAMP) begin
      lim_bin = CLAMP[MAX_W-1:0];
    end
  end

  assign conv_start = (state_q == IDLE) && run;

  bin2bcd_seq #(
    .DIGITS (DIGITS),
    .MAX_W  (MAX_W)
  ) u_conv (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .start  (conv_start),
    .bin    (lim_bin),
    .bcd    (cv_bcd),
    .valid  (cv_valid)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    lim_d    = lim_q;
    down_d   = down_q;
    busy_d   = busy_q;
    done_d   = done_q;
    step_en  = 1'b0;
    hit      = 1'b0;

    start_v = down_q ? lim_q : '0;
    term_v  = down_q ? '0 : lim_q;
    nxt     = bcd_step(digits_q, down_q);
`ifdef BCD_COUNT_WRAP_EN
    if (digits_q == term_v) nxt = start_v;
`endif
    cand = nxt;
    tgt  = term_v;

    if (state_q != IDLE && !run) begin
      state_d  = IDLE;
      digits_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          digits_d = '0;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          if (run) begin
            state_d = CONVERT;
            down_d  = down;
            busy_d  = 1'b1;
          end
        end
        CONVERT: begin
          if (cv_valid) begin
            step_en = 1'b1;
            lim_d   = cv_bcd;
            cand    = down_q ? cv_bcd : '0;
            tgt     = down_q ? '0 : cv_bcd;
          end
        end
        COUNT:   step_en = 1'b1;
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end

    // Shared landing for the first value after conversion and each count step
    if (step_en) begin
      hit      = (cand == tgt);
      digits_d = cand;
      state_d  = COUNT;
      busy_d   = 1'b1;
      done_d   = hit;
`ifndef BCD_COUNT_WRAP_EN
      if (hit) begin
        state_d = DONE;
        busy_d  = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      digits_q <= '0;
      lim_q    <= '0;
      down_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      lim_q    <= lim_d;
      down_q   <= down_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign digits = digits_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
